// File: rtl/data_mem_reader_pkg.sv
// Shared types and constants for the data-memory stream reader.
// The default widths match one 1024 x 32 SoC data memory.
package data_mem_reader_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int MAX_WORDS  = 1 << DEF_ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_stream_reader_fifo.sv
// Small synchronous FIFO that buffers returned memory words for the stream.
// The head entry comes straight from flops, so the stream payload is always registered.
module stream_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (count == '0);
        full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Storage is cleared on reset so the stream payload reads as zero afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/data_mem_stream_reader.sv
// Avalon-MM read master that drains a block of words from a data memory
// and presents them in address order on a valid/ready stream.
module data_mem_stream_reader
    import data_mem_reader_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_LEFT  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   clamped_count;
    logic              in_flight;
    logic              in_flight_last;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_used;
    logic              credit_ok;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_head;
    logic              accept_start;
    logic              zero_start;
    logic              issue;
    logic              issue_last;
    logic              out_fire;
    logic              last_fire;

    // A read may only go out if its word is guaranteed a FIFO slot on return.
    always_comb begin
        clamped_count = (word_count > MAX_COUNT) ? MAX_COUNT : word_count;
        credit_used   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, in_flight};
        credit_ok     = (credit_used < (CNT_W+1)'(FIFO_DEPTH));
        out_valid     = !fifo_empty;
        out_data      = fifo_head[DATA_W-1:0];
        out_last      = out_valid && fifo_head[DATA_W];
        out_fire      = out_valid && out_ready;
        last_fire     = out_fire && out_last;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept_start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (issue_last) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (last_fire) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy         = 1'b0;
        issue        = 1'b0;
        issue_last   = 1'b0;
        accept_start = 1'b0;
        zero_start   = 1'b0;
        case (state)
            IDLE: begin
                accept_start = start && (clamped_count != '0);
                zero_start   = start && (clamped_count == '0);
            end
            RUN: begin
                busy       = 1'b1;
                issue      = credit_ok;
                issue_last = credit_ok && (remaining == ONE_LEFT);
            end
            DRAIN: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Address and count bookkeeping; the last-word flag rides along with the read it belongs to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr           <= '0;
            remaining      <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            done           <= 1'b0;
        end else begin
            done           <= zero_start || ((state == DRAIN) && last_fire);
            in_flight      <= issue;
            in_flight_last <= issue_last;
            if (accept_start) begin
                addr      <= base_addr;
                remaining <= clamped_count;
            end else if (issue) begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

    assign mem_address    = addr;
    assign mem_chipselect = issue;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

    stream_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (in_flight),
        .push_data ({in_flight_last, mem_readdata}),
        .pop       (out_fire),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_data_mem_stream_reader.sv
// Randomised scoreboard bench for data_mem_stream_reader against a 1024-word
// memory model with read latency one.
module tb_data_mem_stream_reader;
    import data_mem_reader_pkg::*;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] word_count;
    logic        busy;
    logic        done;
    logic [9:0]  mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic        mem_clken;
    logic [31:0] mem_readdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    logic [31:0] mem_array [MAX_WORDS];
    exp_t        exp_q [$];
    logic [9:0]  addr_q [$];

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int ready_mode = 0;
    int cur_n = 0;
    int start_cyc = 0;
    int last_hs_cyc = 0;
    int issue_count = 0;
    int outstanding = 0;
    bit cur_zero = 0;
    bit expect_done = 0;
    bit first_cs_pending = 0;
    bit first_valid_pending = 0;
    bit prev_stall = 0;
    logic [31:0] prev_data;
    logic        prev_last;

    data_mem_stream_reader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory s2 port: fixed read latency of one cycle.
    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= mem_array[mem_address];
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = ~out_ready;
                3:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic failNow(input string name, input string msg);
        n_checks++;
        n_fails++;
        $display("[TB] FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_chipselect"}, mem_chipselect, 0);
        checkOutput({tag, "_address"}, mem_address, 0);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_out_last"}, out_last, 0);
        checkOutput({tag, "_out_data"}, out_data, 0);
    endtask

    // Reference model: n = min(count, 1024) words from consecutive addresses modulo 1024.
    task automatic applyStimulus(input logic [9:0] base, input logic [10:0] count, input bit immediate);
        int n;
        logic [9:0] a;
        if (!immediate) begin
            @(posedge clk);
            #1;
        end
        n = (int'(count) > MAX_WORDS) ? MAX_WORDS : int'(count);
        for (int i = 0; i < n; i++) begin
            a = 10'((int'(base) + i) % MAX_WORDS);
            addr_q.push_back(a);
            exp_q.push_back('{data: mem_array[a], last: (i == n - 1)});
        end
        cur_n      = n;
        base_addr  = base;
        word_count = count;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulseIgnoredStart(input logic [9:0] base, input logic [10:0] count);
        @(posedge clk);
        #1;
        base_addr  = base;
        word_count = count;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if (done) break;
        end
        if (k == budget) begin
            failNow("done_timeout", "no done pulse within budget");
            reset_n = 1'b0;
            exp_q.delete();
            addr_q.delete();
            repeat (2) @(posedge clk);
            #3 reset_n = 1'b1;
        end else begin
            checkOutput("words_pending", exp_q.size(), 0);
            checkOutput("reads_pending", addr_q.size(), 0);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and polices timing and credit.
    always @(negedge clk) begin
        if (!reset_n) begin
            outstanding         = 0;
            prev_stall          = 0;
            expect_done         = 0;
            first_cs_pending    = 0;
            first_valid_pending = 0;
        end else begin
            if (done) begin
                if (!expect_done) failNow("done_spurious", "done without a pending transfer");
                else if (cur_zero) checkOutput("done_timing_zero", cyc, start_cyc + 1);
                else checkOutput("done_timing", cyc, last_hs_cyc + 1);
                checkOutput("busy_at_done", busy, 0);
                expect_done = 0;
            end
            if (start && !busy) begin
                start_cyc           = cyc;
                cur_zero            = (cur_n == 0);
                expect_done         = 1;
                first_cs_pending    = (cur_n != 0);
                first_valid_pending = (cur_n != 0);
            end
            if (mem_chipselect) begin
                if (first_cs_pending) begin
                    checkOutput("first_read_cycle", cyc, start_cyc + 1);
                    first_cs_pending = 0;
                end
                if (addr_q.size() == 0) failNow("read_extra", "chipselect with no read expected");
                else checkOutput("read_address", mem_address, addr_q.pop_front());
                outstanding++;
                issue_count++;
                checkOutput("credit_limit", (outstanding <= DEPTH), 1);
            end
            if (out_valid) begin
                if (first_valid_pending) begin
                    checkOutput("first_valid_cycle", cyc, start_cyc + 3);
                    first_valid_pending = 0;
                end
                if (prev_stall) begin
                    checkOutput("hold_data", out_data, prev_data);
                    checkOutput("hold_last", out_last, prev_last);
                end
            end else if (prev_stall) begin
                checkOutput("hold_valid", out_valid, 1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    failNow("word_extra", "stream word with none expected");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("out_data", out_data, e.data);
                    checkOutput("out_last", out_last, e.last);
                end
                outstanding--;
                if (out_last) last_hs_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    initial begin
        int issue_before;
        reset_n    = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        ready_mode = 0;
        for (int k = 0; k < MAX_WORDS; k++) mem_array[k] = 32'hA500_0000 + 32'(k);

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        checkOutput("mem_write", mem_write, 0);
        checkOutput("mem_byteenable", mem_byteenable, 4'hF);
        checkOutput("mem_clken", mem_clken, 1);
        @(posedge clk);
        #3 reset_n = 1'b1;

        $display("[TB] basic read");
        applyStimulus(10'h010, 11'd4, 0);
        waitDone(100);
        checkOutput("basic_done_latency", cyc - start_cyc, 7);

        $display("[TB] address wrap");
        applyStimulus(10'h3FE, 11'd4, 0);
        waitDone(100);

        $display("[TB] backpressure");
        ready_mode   = 3;
        issue_before = issue_count;
        applyStimulus(10'h123, 11'd8, 0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("bp_reads_at_credit", issue_count - issue_before, DEPTH);
        ready_mode = 2;
        waitDone(200);
        ready_mode = 0;

        $display("[TB] zero count");
        issue_before = issue_count;
        applyStimulus(10'h055, 11'd0, 0);
        checkOutput("zero_done", done, 1);
        checkOutput("zero_done_cycle", cyc - start_cyc, 1);
        for (int k = 0; k < 3; k++) begin
            checkOutput("zero_busy", busy, 0);
            @(posedge clk);
            #1;
        end
        checkOutput("zero_no_reads", issue_count - issue_before, 0);

        $display("[TB] start while busy");
        applyStimulus(10'h100, 11'd12, 0);
        pulseIgnoredStart(10'h2AA, 11'd5);
        waitDone(200);

        $display("[TB] reset mid-transfer");
        ready_mode = 1;
        applyStimulus(10'h050, 11'd20, 0);
        repeat (6) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        checkResetValues("abort");
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        ready_mode = 0;
        applyStimulus(10'h000, 11'd2, 0);
        waitDone(100);

        $display("[TB] random transfers");
        for (int k = 0; k < MAX_WORDS; k++) mem_array[k] = $urandom;
        ready_mode = 1;
        for (int t = 0; t < 15; t++) begin
            applyStimulus(10'($urandom_range(0, MAX_WORDS - 1)), 11'($urandom_range(1, 40)),
                          (t != 0) && ($urandom_range(0, 1) == 1));
            waitDone(1000);
        end

        $display("[TB] full memory");
        ready_mode = 0;
        applyStimulus(10'h200, 11'd1024, 0);
        waitDone(3000);
        ready_mode = 1;
        applyStimulus(10'h200, 11'd2047, 0);
        waitDone(8000);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
